// File: rtl/redmule_pkg.sv
// Shared types and default sizing for the RedMulE exponent sequencer.
// Consumers: redmule_exp_sequencer (build option REDMULE_EXP_SEQ_BYPASS_EN lives there).
package redmule_pkg;

    localparam int unsigned DEFAULT_EXP_WIDTH = 8;
    localparam int unsigned DEFAULT_BLOCK_LEN = 32;

    typedef enum logic [1:0] {
        EXP_SEQ_IDLE  = 2'd0,
        EXP_SEQ_FETCH = 2'd1,
        EXP_SEQ_RUN   = 2'd2,
        EXP_SEQ_DONE  = 2'd3
    } exp_seq_state_e;

endpackage

// File: rtl/redmule_exp_sequencer.sv
// Pairs each block of BLOCK_LEN element beats with one shared exponent popped from a buffer.
// Define REDMULE_EXP_SEQ_BYPASS_EN to fetch the next exponent on the last beat (no inter-block bubble).
module redmule_exp_sequencer
    import redmule_pkg::*;
#(
    parameter int unsigned EXP_WIDTH = DEFAULT_EXP_WIDTH,
    parameter int unsigned BLOCK_LEN = DEFAULT_BLOCK_LEN,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] num_blocks_i,
    input  logic [EXP_WIDTH-1:0] exp_data_i,
    input  logic                 exp_valid_i,
    output logic                 exp_consume_o,
    input  logic                 elem_valid_i,
    output logic                 elem_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [EXP_WIDTH-1:0] out_exp_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           dbg_state_o
);

    // Handshake: an element beat moves when elem_valid_i && out_ready_i in RUN;
    // out_valid_o mirrors elem_valid_i and elem_ready_o mirrors out_ready_i, so
    // neither side waits on a combinational loop through this block.

    localparam int unsigned BEAT_W = $clog2(BLOCK_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_LEN - 1);

    exp_seq_state_e       state_q, state_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] blk_q, blk_d;
    logic                 consume;
    logic                 in_run;
    logic                 xfer;

    // Outputs are forced low while rst_i is high so they read 0 during reset too.
    assign in_run = (state_q == EXP_SEQ_RUN) && !rst_i;
    assign xfer   = in_run && elem_valid_i && out_ready_i;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        consume = 1'b0;

        case (state_q)
            EXP_SEQ_IDLE: begin
                if (start_i) begin
                    blk_d   = num_blocks_i;
                    state_d = (num_blocks_i == '0) ? EXP_SEQ_DONE : EXP_SEQ_FETCH;
                end
            end
            EXP_SEQ_FETCH: begin
                if (exp_valid_i) begin
                    consume = 1'b1;
                    exp_d   = exp_data_i;
                    beat_d  = '0;
                    state_d = EXP_SEQ_RUN;
                end
            end
            EXP_SEQ_RUN: begin
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        blk_d = blk_q - 1'b1;
                        if (blk_q == CNT_WIDTH'(1)) begin
                            state_d = EXP_SEQ_DONE;
                        end else begin
`ifdef REDMULE_EXP_SEQ_BYPASS_EN
                            // beat_d already wraps to zero, so the next block starts immediately.
                            if (exp_valid_i) begin
                                consume = 1'b1;
                                exp_d   = exp_data_i;
                            end else begin
                                state_d = EXP_SEQ_FETCH;
                            end
`else
                            state_d = EXP_SEQ_FETCH;
`endif
                        end
                    end
                end
            end
            EXP_SEQ_DONE: begin
                state_d = EXP_SEQ_IDLE;
            end
            default: begin
                state_d = EXP_SEQ_IDLE;
            end
        endcase

        // Soft abort wins over everything, including a start in the same cycle.
        if (clear_i) begin
            state_d = EXP_SEQ_IDLE;
            beat_d  = '0;
            blk_d   = '0;
            consume = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EXP_SEQ_IDLE;
            exp_q   <= '0;
            beat_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
        end
    end

    assign exp_consume_o = consume && !rst_i;
    assign out_valid_o   = in_run && elem_valid_i;
    assign elem_ready_o  = in_run && out_ready_i;
    assign out_exp_o     = in_run ? exp_q : '0;
    assign out_last_o    = in_run && (beat_q == LAST_BEAT);
    assign busy_o        = (state_q != EXP_SEQ_IDLE) && !rst_i;
    assign done_o        = (state_q == EXP_SEQ_DONE) && !rst_i;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_redmule_exp_sequencer.sv
// Directed self-checking bench for redmule_exp_sequencer; cycle-count expectations follow
// REDMULE_EXP_SEQ_BYPASS_EN when it is defined for the build.
module tb_redmule_exp_sequencer;
    import redmule_pkg::*;

`ifdef REDMULE_EXP_SEQ_BYPASS_EN
    localparam int JOB3_CYCLES = 99;
`else
    localparam int JOB3_CYCLES = 101;
`endif

    logic        clk;
    logic        rst_i;
    logic        clear_i;
    logic        start_i;
    logic [15:0] num_blocks_i;
    logic [7:0]  exp_data_i;
    logic        exp_valid_i;
    logic        exp_consume_o;
    logic        elem_valid_i;
    logic        elem_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_exp_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    redmule_exp_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .num_blocks_i (num_blocks_i),
        .exp_data_i   (exp_data_i),
        .exp_valid_i  (exp_valid_i),
        .exp_consume_o(exp_consume_o),
        .elem_valid_i (elem_valid_i),
        .elem_ready_o (elem_ready_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_exp_o    (out_exp_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exponent buffer model and monitor
    logic [7:0] exp_src_q[$];
    logic       exp_en;
    bit         pop_pend;
    int         n_consume, n_done, n_busy, stall_err, cons_err;
    logic [7:0] beat_exp_q[$];
    logic       beat_last_q[$];
    logic       prev_stall;
    logic [7:0] prev_exp;

    task automatic refresh_buf();
        exp_valid_i = exp_en && (exp_src_q.size() > 0);
        exp_data_i  = (exp_src_q.size() > 0) ? exp_src_q[0] : 8'h00;
    endtask

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            if (exp_src_q.size() > 0) void'(exp_src_q.pop_front());
            pop_pend = 1'b0;
        end
        refresh_buf();
    end

    always @(negedge clk) begin
        if (exp_consume_o) begin
            n_consume++;
            pop_pend = 1'b1;
            if (!exp_valid_i || clear_i) cons_err++;
        end
        if (done_o) n_done++;
        if (busy_o) n_busy++;
        if (out_valid_o && out_ready_i && !clear_i && !rst_i) begin
            beat_exp_q.push_back(out_exp_o);
            beat_last_q.push_back(out_last_o);
        end
        if (prev_stall && out_valid_o && out_exp_o !== prev_exp) stall_err++;
        prev_stall = out_valid_o && !out_ready_i;
        prev_exp   = out_exp_o;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        n_consume = 0; n_done = 0; n_busy = 0; stall_err = 0; cons_err = 0;
        beat_exp_q.delete();
        beat_last_q.delete();
        exp_src_q.delete();
        pop_pend   = 1'b0;
        prev_stall = 1'b0;
        refresh_buf();
    endtask

    task automatic start_job(input logic [15:0] num);
        tick();
        start_i      = 1'b1;
        num_blocks_i = num;
        tick();
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done_o expected done within %0d cycles", name, budget);
        end
    endtask

    // Tests
    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o});
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o} !== 14'h0) begin
                errors++;
                $display("FAIL post_reset_outputs: got %0h expected 0",
                         {exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o});
            end
            checks++;
            if (dbg_state_o !== EXP_SEQ_IDLE) begin
                errors++;
                $display("FAIL post_reset_state: got %0d expected %0d", dbg_state_o, EXP_SEQ_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_three_blocks();
        logic [7:0] e;
        clear_mon();
        exp_src_q.push_back(8'h10);
        exp_src_q.push_back(8'h20);
        exp_src_q.push_back(8'h30);
        exp_en = 1'b1; elem_valid_i = 1'b1; out_ready_i = 1'b1;
        refresh_buf();
        start_job(16'd3);
        wait_done(400, "three_blocks");
        tick();
        tick();
        checks++;
        if (beat_exp_q.size() != 96) begin
            errors++;
            $display("FAIL three_beats: got %0d expected 96", beat_exp_q.size());
        end else begin
            for (int i = 0; i < 96; i++) begin
                e = 8'h10 * 8'(i / 32 + 1);
                checks++;
                if (beat_exp_q[i] !== e || beat_last_q[i] !== ((i % 32) == 31)) begin
                    errors++;
                    $display("FAIL three_beat_%0d: got exp %0h last %0b expected exp %0h last %0b",
                             i, beat_exp_q[i], beat_last_q[i], e, (i % 32) == 31);
                end
            end
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL three_done: got %0d expected 1", n_done); end
        checks++;
        if (n_consume != 3) begin errors++; $display("FAIL three_consumes: got %0d expected 3", n_consume); end
        checks++;
        if (n_busy + 1 != JOB3_CYCLES) begin
            errors++;
            $display("FAIL three_cycles: got %0d expected %0d", n_busy + 1, JOB3_CYCLES);
        end
        checks++;
        if (cons_err != 0) begin errors++; $display("FAIL three_consume_rule: got %0d expected 0", cons_err); end
    endtask

    task automatic test_zero_blocks();
        clear_mon();
        exp_src_q.push_back(8'h44);
        exp_en = 1'b1;
        refresh_buf();
        tick();
        start_i = 1'b1; num_blocks_i = 16'd0;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %0b expected 0", done_o); end
        tick();
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_done_pulse: got done %0b busy %0b expected 1 1", done_o, busy_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_back_idle: got done %0b busy %0b expected 0 0", done_o, busy_o);
        end
        checks++;
        if (n_consume != 0 || beat_exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_activity: got consumes %0d beats %0d expected 0 0", n_consume, beat_exp_q.size());
        end
    endtask

    task automatic test_fetch_stall();
        clear_mon();
        exp_src_q.push_back(8'h5A);
        exp_en = 1'b0; elem_valid_i = 1'b1; out_ready_i = 1'b1;
        refresh_buf();
        start_job(16'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (exp_consume_o !== 1'b0 || out_valid_o !== 1'b0 || dbg_state_o !== EXP_SEQ_FETCH) begin
                errors++;
                $display("FAIL fetch_hold_%0d: got consume %0b valid %0b state %0d expected 0 0 %0d",
                         i, exp_consume_o, out_valid_o, dbg_state_o, EXP_SEQ_FETCH);
            end
            tick();
        end
        exp_en = 1'b1;
        refresh_buf();
        @(negedge clk);
        checks++;
        if (exp_consume_o !== 1'b1) begin errors++; $display("FAIL fetch_resume: got %0b expected 1", exp_consume_o); end
        wait_done(100, "fetch_stall");
        tick();
        checks++;
        if (beat_exp_q.size() != 32 || n_consume != 1) begin
            errors++;
            $display("FAIL fetch_counts: got beats %0d consumes %0d expected 32 1", beat_exp_q.size(), n_consume);
        end else begin
            checks++;
            if (beat_exp_q[0] !== 8'h5A || beat_exp_q[31] !== 8'h5A || beat_last_q[31] !== 1'b1) begin
                errors++;
                $display("FAIL fetch_beats: got %0h %0h last %0b expected 5a 5a 1",
                         beat_exp_q[0], beat_exp_q[31], beat_last_q[31]);
            end
        end
    endtask

    task automatic test_random_ready();
        bit seen;
        clear_mon();
        exp_src_q.push_back(8'h11);
        exp_src_q.push_back(8'h22);
        exp_en = 1'b1; elem_valid_i = 1'b1;
        out_ready_i = 1'($urandom_range(0, 1));
        refresh_buf();
        start_job(16'd2);
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        out_ready_i = 1'b1;
        checks++;
        if (!seen) begin errors++; $display("FAIL random_done_timeout: got no done_o expected done"); end
        tick();
        checks++;
        if (beat_exp_q.size() != 64) begin
            errors++;
            $display("FAIL random_beats: got %0d expected 64", beat_exp_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (beat_exp_q[i] !== ((i < 32) ? 8'h11 : 8'h22) || beat_last_q[i] !== ((i % 32) == 31)) begin
                    errors++;
                    $display("FAIL random_beat_%0d: got exp %0h last %0b expected exp %0h last %0b",
                             i, beat_exp_q[i], beat_last_q[i], (i < 32) ? 8'h11 : 8'h22, (i % 32) == 31);
                end
            end
        end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL random_stall_stable: got %0d expected 0", stall_err); end
        checks++;
        if (n_consume != 2) begin errors++; $display("FAIL random_consumes: got %0d expected 2", n_consume); end
    endtask

    task automatic test_clear();
        clear_mon();
        exp_src_q.push_back(8'hA1);
        exp_src_q.push_back(8'hA2);
        exp_src_q.push_back(8'hA3);
        exp_src_q.push_back(8'hA4);
        exp_en = 1'b1; elem_valid_i = 1'b1; out_ready_i = 1'b1;
        refresh_buf();
        start_job(16'd4);
        for (int i = 0; i < 200; i++) begin
            if (beat_exp_q.size() == 42) break;
            tick();
        end
        clear_i = 1'b1; start_i = 1'b1; num_blocks_i = 16'd5;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_exp_o !== 8'hA2) begin
            errors++;
            $display("FAIL clear_at_beat: got valid %0b exp %0h expected 1 a2", out_valid_o, out_exp_o);
        end
        checks++;
        if (exp_consume_o !== 1'b0) begin errors++; $display("FAIL clear_no_consume: got %0b expected 0", exp_consume_o); end
        tick();
        clear_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || dbg_state_o !== EXP_SEQ_IDLE || out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL clear_idle_%0d: got busy %0b state %0d valid %0b expected 0 %0d 0",
                         i, busy_o, dbg_state_o, out_valid_o, EXP_SEQ_IDLE);
            end
            tick();
        end
        checks++;
        if (n_done != 0 || n_consume != 2 || exp_src_q.size() != 2) begin
            errors++;
            $display("FAIL clear_counts: got done %0d consumes %0d left %0d expected 0 2 2",
                     n_done, n_consume, exp_src_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        clear_mon();
        exp_src_q.push_back(8'h31);
        exp_src_q.push_back(8'h32);
        exp_en = 1'b1; elem_valid_i = 1'b1; out_ready_i = 1'b1;
        refresh_buf();
        start_job(16'd2);
        for (int i = 0; i < 100; i++) begin
            if (beat_exp_q.size() == 5) break;
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o} !== 14'h0
            || dbg_state_o !== EXP_SEQ_IDLE) begin
            errors++;
            $display("FAIL midrun_reset: got outs %0h state %0d expected 0 %0d",
                     {exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o},
                     dbg_state_o, EXP_SEQ_IDLE);
        end
        clear_mon();
        exp_src_q.push_back(8'h77);
        refresh_buf();
        start_job(16'd1);
        wait_done(100, "midrun_restart");
        tick();
        checks++;
        if (beat_exp_q.size() != 32 || n_consume != 1 || n_done != 1) begin
            errors++;
            $display("FAIL midrun_restart_counts: got beats %0d consumes %0d done %0d expected 32 1 1",
                     beat_exp_q.size(), n_consume, n_done);
        end else begin
            checks++;
            if (beat_exp_q[31] !== 8'h77 || beat_last_q[31] !== 1'b1 || beat_last_q[30] !== 1'b0) begin
                errors++;
                $display("FAIL midrun_restart_beats: got %0h last %0b/%0b expected 77 1/0",
                         beat_exp_q[31], beat_last_q[31], beat_last_q[30]);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; num_blocks_i = 16'd0;
        elem_valid_i = 1'b0; out_ready_i = 1'b0; exp_en = 1'b0;
        clear_mon();
        test_reset();
        test_three_blocks();
        test_zero_blocks();
        test_fetch_stall();
        test_random_ready();
        test_clear();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/redmule_exp_sequencer.md
REDMULE_EXP_SEQUENCER -- requirements
Module: redmule_exp_sequencer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, meaning the width of one shared exponent.
REQ-002 SHALL have parameter BLOCK_LEN, default 32, meaning the number of element beats covered by one exponent (power of two, >=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the block-count field.
REQ-004 SHALL provide: clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL provide: rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL provide: clear_i  in  1  synchronous soft abort.
REQ-007 SHALL provide: start_i  in  1  job start pulse; num_blocks_i  in  CNT_WIDTH  exponents to consume in the job.
REQ-008 SHALL provide: exp_data_i  in  EXP_WIDTH  head exponent from the exponent buffer; exp_valid_i  in  1  buffer not empty; exp_consume_o  out  1  pop request to the buffer.
REQ-009 SHALL provide: elem_valid_i  in  1; elem_ready_o  out  1  upstream element-beat handshake.
REQ-010 SHALL provide: out_valid_o  out  1; out_ready_i  in  1; out_exp_o  out  EXP_WIDTH  exponent paired with the current beat; out_last_o  out  1  last beat of the block.
REQ-011 SHALL provide: busy_o  out  1; done_o  out  1  one-cycle job-complete pulse.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, RUN and DONE.
REQ-013 IDLE: on start_i, SHALL latch num_blocks_i into a remaining-block counter; the next state SHALL be FETCH, or DONE if num_blocks_i==0.
REQ-014 FETCH: when exp_valid_i=1, SHALL assert exp_consume_o in that same cycle, latch exp_data_i into the exponent register, clear the beat counter and go to RUN; otherwise it SHALL hold.
REQ-015 exp_consume_o SHALL never be asserted while exp_valid_i=0, in IDLE or DONE, or while clear_i=1.
REQ-016 RUN: SHALL set out_valid_o = elem_valid_i, elem_ready_o = out_ready_i, and out_exp_o = the exponent register; a beat transfers when elem_valid_i && out_ready_i.
REQ-017 Outside RUN, out_valid_o and elem_ready_o SHALL be 0.
REQ-018 The beat counter (clog2(BLOCK_LEN) bits) SHALL increment per transfer; out_last_o SHALL be asserted when the counter equals BLOCK_LEN-1 and the FSM is in RUN.
REQ-019 On the last-beat transfer, SHALL decrement the remaining-block counter; if the result is 0 the next state SHALL be DONE, otherwise it SHALL be FETCH (or bypass per REQ-027).
REQ-020 DONE: SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 start_i SHALL be ignored when the FSM is not in IDLE.
REQ-023 A stalled beat (out_ready_i=0) SHALL hold the counter and exponent; out_exp_o SHALL stay stable while out_valid_o=1.
REQ-024 clear_i SHALL force IDLE and zero both counters next cycle, with no consume and no done_o; clear_i SHALL take priority over start_i.

Reset
REQ-025 With rst_i=1 at a clock edge, SHALL go to IDLE with the exponent register and both counters zeroed; this SHALL also apply mid-job.
REQ-026 While in reset and after it, all outputs SHALL read 0 (exp_consume_o, elem_ready_o, out_valid_o, out_last_o, busy_o, done_o, out_exp_o) until the first start_i.

Configuration
REQ-027 Macro REDMULE_EXP_SEQ_BYPASS_EN defined: on a non-final last-beat transfer with exp_valid_i=1, SHALL consume and latch the next exponent in that same cycle and stay in RUN, giving zero bubble between blocks; with exp_valid_i=0 it SHALL go to FETCH.
REQ-028 Macro absent: SHALL always pass through FETCH between blocks, a one-cycle minimum bubble.

Structure
REQ-029 The FSM state enum and the default EXP_WIDTH/BLOCK_LEN constants SHALL reside in redmule_pkg.
REQ-030 There SHALL be no sub-module; counters and FSM SHALL be implemented inline.

Verification
REQ-031 Reset mid-RUN (beat 5 of block 1): next cycle SHALL be IDLE with all outputs 0; a subsequent start with num_blocks=1 SHALL complete normally.
REQ-032 num_blocks=3, exponents 0x10/0x20/0x30 always valid, out_ready=1: 96 beats SHALL arrive with out_exp 0x10x32, 0x20x32, 0x30x32 and out_last at beats 31/63/95; done_o SHALL pulse once; exactly 3 consumes SHALL occur; total cycles SHALL be 99 with the macro and 101 without.
REQ-033 num_blocks=0: done_o SHALL pulse 1 cycle after start, with zero consumes and zero beats.
REQ-034 exp_valid_i held low 10 cycles in FETCH: SHALL stay in FETCH with no consume and out_valid_o=0; it SHALL resume on the valid cycle.
REQ-035 Random out_ready_i at 50% on a 2-block job: no beat loss or duplication, out_exp_o stable under stall, exactly 2 consumes.
REQ-036 clear_i asserted at beat 10 of block 2 of 4: SHALL go to IDLE next cycle with no done_o and no further consumes; start_i in the clear cycle SHALL be ignored.
